// File: rtl/pwm_audio_out.sv
// pwm_audio_out: stereo PWM audio DAC stage with first-order error-feedback
// noise shaping on the truncated low sample bits.
//
// Ports:
//   clk_pixel      - sole clock
//   reset_n        - asynchronous active-low reset
//   sample_valid   - a signed sample pair is offered
//   sample_ready   - FIFO can accept a pair (not full)
//   sample_left    - signed left sample
//   sample_right   - signed right sample
//   sample_dropped - high in a cycle where an offer is rejected
//   fifo_level     - current FIFO occupancy
//   pwm_left       - left PWM output
//   pwm_right      - right PWM output
module pwm_audio_out #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk_pixel,
  input  logic                          reset_n,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic [SAMPLE_WIDTH-1:0]       sample_left,
  input  logic [SAMPLE_WIDTH-1:0]       sample_right,
  output logic                          sample_dropped,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          pwm_left,
  output logic                          pwm_right
);

  localparam int unsigned ACC_W = SAMPLE_WIDTH - PWM_BITS;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [PWM_BITS-1:0] CNT_MAX   = '1;
  localparam logic [PWM_BITS-1:0] DUTY_MID  = {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic [LVL_W-1:0]    LVL_FULL  = LVL_W'(FIFO_DEPTH);

  // Sample pair storage (no reset needed; occupancy tracks validity)
  logic [SAMPLE_WIDTH-1:0] mem_l_q [FIFO_DEPTH];
  logic [SAMPLE_WIDTH-1:0] mem_r_q [FIFO_DEPTH];

  logic [PWM_BITS-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [ACC_W-1:0]        acc_l_q, acc_l_d;
  logic [ACC_W-1:0]        acc_r_q, acc_r_d;
  logic [PWM_BITS-1:0]     duty_l_q, duty_l_d;
  logic [PWM_BITS-1:0]     duty_r_q, duty_r_d;
  logic                    pwm_l_q, pwm_l_d;
  logic                    pwm_r_q, pwm_r_d;

  logic                    boundary;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic [SAMPLE_WIDTH-1:0] cur_l;
  logic [SAMPLE_WIDTH-1:0] cur_r;
  logic [PWM_BITS+ACC_W-1:0] conv_l;
  logic [PWM_BITS+ACC_W-1:0] conv_r;

  // Offset-binary split into duty (high bits) plus carry out of the
  // error accumulator fed with the truncated low bits; returns {duty, acc}.
  function automatic logic [PWM_BITS+ACC_W-1:0] convert(
    input logic [SAMPLE_WIDTH-1:0] s,
    input logic [ACC_W-1:0]        acc
  );
    logic [SAMPLE_WIDTH-1:0] u;
    logic [ACC_W:0]          sum;
    logic [PWM_BITS:0]       hi_c;
    logic [PWM_BITS-1:0]     duty;
    u    = {~s[SAMPLE_WIDTH-1], s[SAMPLE_WIDTH-2:0]};
    sum  = {1'b0, acc} + {1'b0, u[ACC_W-1:0]};
    hi_c = {1'b0, u[SAMPLE_WIDTH-1 -: PWM_BITS]} + (PWM_BITS+1)'(sum[ACC_W]);
    duty = hi_c[PWM_BITS] ? '1 : hi_c[PWM_BITS-1:0];
    return {duty, sum[ACC_W-1:0]};
  endfunction

  // Handshake: readiness comes from registered occupancy only
  assign full           = (level_q == LVL_FULL);
  assign sample_ready   = ~full;
  assign sample_dropped = sample_valid & full;
  assign boundary       = (cnt_q == CNT_MAX);
  assign push           = sample_valid & ~full;
  assign pop            = boundary & (level_q != '0);

  // A pair popped this boundary is converted immediately
  assign cur_l  = pop ? mem_l_q[rd_ptr_q] : hold_l_q;
  assign cur_r  = pop ? mem_r_q[rd_ptr_q] : hold_r_q;
  assign conv_l = convert(cur_l, acc_l_q);
  assign conv_r = convert(cur_r, acc_r_q);

  // Next-state logic
  always_comb begin
    cnt_d    = cnt_q + PWM_BITS'(1);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    duty_l_d = duty_l_q;
    duty_r_d = duty_r_q;
    pwm_l_d  = (cnt_q < duty_l_q);
    pwm_r_d  = (cnt_q < duty_r_q);

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (boundary) begin
      hold_l_d = cur_l;
      hold_r_d = cur_r;
      duty_l_d = conv_l[PWM_BITS+ACC_W-1 -: PWM_BITS];
      duty_r_d = conv_r[PWM_BITS+ACC_W-1 -: PWM_BITS];
      acc_l_d  = conv_l[ACC_W-1:0];
      acc_r_d  = conv_r[ACC_W-1:0];
    end
  end

  // FIFO storage write
  always_ff @(posedge clk_pixel) begin
    if (push) begin
      mem_l_q[wr_ptr_q] <= sample_left;
      mem_r_q[wr_ptr_q] <= sample_right;
    end
  end

  // State registers
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      duty_l_q <= DUTY_MID;
      duty_r_q <= DUTY_MID;
      pwm_l_q  <= 1'b0;
      pwm_r_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      duty_l_q <= duty_l_d;
      duty_r_q <= duty_r_d;
      pwm_l_q  <= pwm_l_d;
      pwm_r_q  <= pwm_r_d;
    end
  end

  assign fifo_level = level_q;
  assign pwm_left   = pwm_l_q;
  assign pwm_right  = pwm_r_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out: randomized bench for pwm_audio_out with an arithmetic
// reference model (queue + integer math) checked every cycle, plus literal
// duty-cycle expectations measured over whole PWM periods.
module tb_pwm_audio_out;

  localparam int SW    = 16;
  localparam int PB    = 8;
  localparam int DEPTH = 4;
  localparam int PER   = 256;

  logic        clk_pixel    = 1'b0;
  logic        reset_n      = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_left  = '0;
  logic [15:0] sample_right = '0;
  logic        sample_ready;
  logic        sample_dropped;
  logic [2:0]  fifo_level;
  logic        pwm_left;
  logic        pwm_right;

  always #5 clk_pixel = ~clk_pixel;

  pwm_audio_out #(.SAMPLE_WIDTH(SW), .PWM_BITS(PB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_pixel      (clk_pixel),
    .reset_n        (reset_n),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .sample_left    (sample_left),
    .sample_right   (sample_right),
    .sample_dropped (sample_dropped),
    .fifo_level     (fifo_level),
    .pwm_left       (pwm_left),
    .pwm_right      (pwm_right)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int          m_cnt    = 0;
  int          m_acc_l  = 0;
  int          m_acc_r  = 0;
  int          m_duty_l = 128;
  int          m_duty_r = 128;
  bit          m_pwm_l  = 1'b0;
  bit          m_pwm_r  = 1'b0;
  logic [15:0] m_hold_l = '0;
  logic [15:0] m_hold_r = '0;
  logic [31:0] m_q[$];

  // duty = top 8 bits of (sample + 32768) plus carry of the low-byte accumulator
  function automatic int conv(input logic [15:0] s, input int acc_in, output int acc_out);
    int u, t, d;
    u       = int'($signed(s)) + 32768;
    t       = acc_in + (u % 256);
    acc_out = t % 256;
    d       = (u / 256) + (t / 256);
    if (d > 255) d = 255;
    return d;
  endfunction

  always @(posedge clk_pixel or negedge reset_n) begin : model
    bit          push;
    logic [31:0] p;
    int          na;
    if (!reset_n) begin
      m_cnt = 0; m_q.delete();
      m_hold_l = '0; m_hold_r = '0;
      m_acc_l = 0; m_acc_r = 0;
      m_duty_l = 128; m_duty_r = 128;
      m_pwm_l = 1'b0; m_pwm_r = 1'b0;
    end else begin
      push    = sample_valid && (m_q.size() < DEPTH);
      m_pwm_l = (m_cnt < m_duty_l);
      m_pwm_r = (m_cnt < m_duty_r);
      if (m_cnt == PER - 1) begin
        if (m_q.size() > 0) begin
          p = m_q.pop_front();
          m_hold_l = p[31:16];
          m_hold_r = p[15:0];
        end
        m_duty_l = conv(m_hold_l, m_acc_l, na); m_acc_l = na;
        m_duty_r = conv(m_hold_r, m_acc_r, na); m_acc_r = na;
      end
      if (push) m_q.push_back({sample_left, sample_right});
      m_cnt = (m_cnt + 1) % PER;
    end
  end

  // ---------------- per-cycle compare + period high counts ----------------
  int win_l = 0;
  int win_r = 0;
  int per_l[$];
  int per_r[$];

  always @(negedge clk_pixel) begin
    check("pwm_left",       int'(pwm_left),       int'(m_pwm_l));
    check("pwm_right",      int'(pwm_right),      int'(m_pwm_r));
    check("fifo_level",     int'(fifo_level),     m_q.size());
    check("sample_ready",   int'(sample_ready),   (m_q.size() < DEPTH) ? 1 : 0);
    check("sample_dropped", int'(sample_dropped),
          (sample_valid && (m_q.size() >= DEPTH)) ? 1 : 0);
    if (!reset_n) begin
      win_l = 0; win_r = 0;
    end else begin
      // output window of a period starts one clock after cnt == 0
      if (m_cnt == 1) begin
        per_l.push_back(win_l); per_r.push_back(win_r);
        win_l = 0; win_r = 0;
      end
      win_l += pwm_left  ? 1 : 0;
      win_r += pwm_right ? 1 : 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_pixel); #1;
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    while (m_cnt != v && n < 2 * PER) begin tick(); n++; end
    if (m_cnt != v) check("wait_cnt_timeout", m_cnt, v);
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    sample_valid = 1'b1; sample_left = l; sample_right = r;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic periods(input int n);
    repeat (n * PER) tick();
  endtask

  task automatic drain();
    int n = 0;
    while (fifo_level != 0 && n < 6 * PER) begin tick(); n++; end
    check("drain_timeout", int'(fifo_level), 0);
  endtask

  int a, b;

  initial begin
    // reset state
    repeat (3) @(posedge clk_pixel);
    #1;
    check("rst_fifo_level", int'(fifo_level), 0);
    check("rst_ready",      int'(sample_ready), 1);
    check("rst_pwm_left",   int'(pwm_left), 0);
    check("rst_pwm_right",  int'(pwm_right), 0);
    check("rst_dropped",    int'(sample_dropped), 0);
    reset_n = 1'b1;

    // idle midscale
    periods(3);
    check("idle_left_128",  per_l[$], 128);
    check("idle_right_128", per_r[$], 128);

    // full-scale extremes
    wait_cnt(50);
    push(16'h7FFF, 16'h8000);
    periods(3);
    check("max_left_255", per_l[$], 255);
    check("min_right_0",  per_r[$], 0);

    // noise-shaped half-LSB: 128/129 alternation
    wait_cnt(50);
    push(16'h0080, 16'h0080);
    periods(4);
    a = per_l[$]; b = per_l[$-1];
    check("alt_left_sum",  a + b, 257);
    check("alt_left_diff", (a > b) ? a - b : b - a, 1);
    a = per_r[$]; b = per_r[$-1];
    check("alt_right_sum",  a + b, 257);
    check("alt_right_diff", (a > b) ? a - b : b - a, 1);

    // overflow: 5 back-to-back offers mid-period
    wait_cnt(100);
    sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample_left  = 16'($urandom);
      sample_right = 16'($urandom);
      if (i == 4) begin
        #1;
        check("ovf_dropped_pulse", int'(sample_dropped), 1);
        check("ovf_ready_low",     int'(sample_ready), 0);
      end
      tick();
    end
    sample_valid = 1'b0;
    #1;
    check("ovf_level_4",    int'(fifo_level), 4);
    check("ovf_dropped_end", int'(sample_dropped), 0);
    wait_cnt(0);
    check("ovf_pop_level_3", int'(fifo_level), 3);
    check("ovf_pop_ready",   int'(sample_ready), 1);
    drain();

    // push into empty FIFO on the boundary cycle
    wait_cnt(255);
    push(16'h1234, 16'hC000);
    check("bnd_level_1_start", int'(fifo_level), 1);
    wait_cnt(128);
    check("bnd_level_1_mid", int'(fifo_level), 1);
    wait_cnt(0);
    check("bnd_popped_next", int'(fifo_level), 0);

    // randomized traffic: sparse then bursty
    repeat (4000) begin
      sample_valid = ($urandom_range(0, 99) < 3);
      sample_left  = 16'($urandom);
      sample_right = 16'($urandom);
      tick();
    end
    repeat (800) begin
      sample_valid = ($urandom_range(0, 3) == 0);
      sample_left  = 16'($urandom);
      sample_right = 16'($urandom);
      tick();
    end
    sample_valid = 1'b0;
    drain();

    // asynchronous reset mid-period with queued pairs
    wait_cnt(10);
    push(16'h7FFF, 16'h7FFF);
    wait_cnt(0);
    wait_cnt(10);
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    push(16'h5555, 16'h6666);
    wait_cnt(100);
    check("pre_rst_level_3", int'(fifo_level), 3);
    check("pre_rst_pwm_hi",  int'(pwm_left), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_pwm_left",  int'(pwm_left), 0);
    check("async_rst_pwm_right", int'(pwm_right), 0);
    check("async_rst_level",     int'(fifo_level), 0);
    check("async_rst_ready",     int'(sample_ready), 1);
    tick();
    reset_n = 1'b1;
    periods(3);
    check("post_rst_left_128",  per_l[$], 128);
    check("post_rst_right_128", per_r[$], 128);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
